// File: rtl/fft_mag_frame_buffer.sv
// Ping-pong frame buffer for 256-bin CORDIC magnitude frames, with a synchronous read port.
// Define PHASE_STORE_EN to store and return the full {phase, magnitude} beat instead of magnitude only.
module fft_mag_frame_buffer #(
  parameter int DATA_WIDTH = 48,
  parameter int MAG_WIDTH  = 24,
  parameter int BINS       = 256,
  parameter int ADDR_WIDTH = 8,
`ifdef PHASE_STORE_EN
  localparam int RD_WIDTH  = DATA_WIDTH
`else
  localparam int RD_WIDTH  = MAG_WIDTH
`endif
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_WIDTH-1:0]   rd_data,
  output logic                  rd_valid,
  input  logic                  rd_release,
  output logic                  frame_ready,
  output logic [15:0]           frame_cnt,
  output logic                  err_tlast_early,
  output logic                  err_tlast_missing
);

  logic                  r_aresetn_q;
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic [15:0]           r_frame_cnt;
  logic                  r_err_early;
  logic                  r_err_missing;
  logic [RD_WIDTH-1:0]   r_rd_data;
  logic                  r_rd_valid;

  // Bank select is the MSB of the memory address: {bank, bin}.
  logic [RD_WIDTH-1:0]   r_mem [0:(2**(ADDR_WIDTH+1))-1];

  logic [1:0]            w_full_next;
  logic                  w_tready;
  logic                  w_accept;
  logic                  w_last_bin;
  logic                  w_close;
  logic                  w_frame_ready;
  logic                  w_release;
  logic                  w_rd_fire;
  logic [RD_WIDTH-1:0]   w_wr_data;

`ifdef PHASE_STORE_EN
  assign w_wr_data = s_axis_tdata;
`else
  logic w_unused_phase;
  assign w_wr_data      = s_axis_tdata[MAG_WIDTH-1:0];
  assign w_unused_phase = ^s_axis_tdata[DATA_WIDTH-1:MAG_WIDTH];
`endif

  // Live aresetn is included so tready is already low on the first reset cycle.
  assign w_tready      = r_aresetn_q && aresetn && !r_full[r_wr_bank];
  assign w_accept      = s_axis_tvalid && w_tready;
  assign w_last_bin    = (r_wr_cnt == ADDR_WIDTH'(BINS - 1));
  assign w_close       = w_accept && (s_axis_tlast || w_last_bin);
  assign w_frame_ready = r_full[r_rd_bank];
  assign w_release     = rd_release && w_frame_ready;
  assign w_rd_fire     = rd_en && w_frame_ready;

  // Close and release never target the same bank: close needs it empty, release needs it full.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      assign w_full_next[gi] = (w_close && (r_wr_bank == 1'(gi))) ? 1'b1 :
                               (w_release && (r_rd_bank == 1'(gi))) ? 1'b0 :
                               r_full[gi];
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_aresetn_q <= 1'b0;
    end else begin
      r_aresetn_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_full        <= 2'b00;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_cnt      <= '0;
      r_frame_cnt   <= 16'd0;
      r_err_early   <= 1'b0;
      r_err_missing <= 1'b0;
    end else begin
      r_full <= w_full_next;
      if (w_close) begin
        r_wr_bank   <= ~r_wr_bank;
        r_wr_cnt    <= '0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (s_axis_tlast && !w_last_bin) begin
          r_err_early <= 1'b1;
        end
        if (w_last_bin && !s_axis_tlast) begin
          r_err_missing <= 1'b1;
        end
      end else if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + ADDR_WIDTH'(1);
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_accept) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= w_wr_data;
    end
  end

  // The read samples r_rd_bank before any same-cycle release toggles it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= r_mem[{r_rd_bank, rd_addr}];
      end
    end
  end

  assign s_axis_tready     = w_tready;
  assign rd_data           = r_rd_data;
  assign rd_valid          = r_rd_valid;
  assign frame_ready       = w_frame_ready;
  assign frame_cnt         = r_frame_cnt;
  assign err_tlast_early   = r_err_early;
  assign err_tlast_missing = r_err_missing;

endmodule

// File: tb/tb_fft_mag_frame_buffer.sv
// Directed bench for fft_mag_frame_buffer; read results are checked against a queue of expected words.
module tb_fft_mag_frame_buffer;
`ifdef PHASE_STORE_EN
  localparam int RW = 48;
`else
  localparam int RW = 24;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [47:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_addr = '0;
  logic [RW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_release = 1'b0;
  logic          frame_ready;
  logic [15:0]   frame_cnt;
  logic          err_tlast_early;
  logic          err_tlast_missing;

  int n_checks = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q[$];

  fft_mag_frame_buffer dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .frame_ready(frame_ready), .frame_cnt(frame_cnt),
    .err_tlast_early(err_tlast_early), .err_tlast_missing(err_tlast_missing)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] stored(input logic [47:0] d);
`ifdef PHASE_STORE_EN
    return d;
`else
    return d[23:0];
`endif
  endfunction

  function automatic logic [47:0] beat(input logic [23:0] tag, input int i);
    return {~tag ^ 24'(i * 3), 24'(tag + 24'(i))};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    logic [RW-1:0] e;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", rd_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
        $display("read: data %0h expected %0h", rd_data, e);
      end
    end
  end

  task automatic send_beat(input logic [47:0] d, input bit last);
    int n;
    bit rdy;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    while (1) begin
      rdy = s_axis_tready;
      tick();
      if (rdy) break;
      n++;
      if (n > 20) begin
        check("tready_timeout", s_axis_tready, 1'b1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] tag, input int n, input int last_at);
    for (int i = 0; i < n; i++) send_beat(beat(tag, i), (i == last_at));
    $display("frame: tag %0h beats %0d last_at %0d frame_cnt %0d", tag, n, last_at, frame_cnt);
  endtask

  task automatic rd(input logic [7:0] a, input logic [47:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(stored(d));
    tick();
    rd_en = 1'b0;
    check("rd_valid_latency", rd_valid, 1'b1);
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic do_reset(input int n);
    int k;
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (n) tick();
    check("tready_in_reset", s_axis_tready, 1'b0);
    aresetn = 1'b1;
    exp_q.delete();
    k = 0;
    while (!s_axis_tready && k < 10) begin
      tick();
      k++;
    end
    check("tready_after_reset", s_axis_tready, 1'b1);
    $display("reset: released after %0d cycles", n);
  endtask

  initial begin
    // Reset state
    do_reset(3);
    check("rst_frame_ready", frame_ready, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_err_early", err_tlast_early, 1'b0);
    check("rst_err_missing", err_tlast_missing, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, '0);

    // Single frame, bin index as magnitude
    for (int i = 0; i < 255; i++) send_beat(beat(24'h0, i), 1'b0);
    check("fr_before_last", frame_ready, 1'b0);
    send_beat(beat(24'h0, 255), 1'b1);
    check("fr_after_last", frame_ready, 1'b1);
    check("cnt_frame1", frame_cnt, 16'd1);
    check("tready_bank1_free", s_axis_tready, 1'b1);
    rd(8'd0, beat(24'h0, 0));
    rd(8'd17, beat(24'h0, 17));
    rd(8'd255, beat(24'h0, 255));
    tick();

    // Fill the second bank: both full, frame 3 stalls until a release
    send_frame(24'h100000, 256, 255);
    check("tready_both_full", s_axis_tready, 1'b0);
    check("cnt_frame2", frame_cnt, 16'd2);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = beat(24'h200000, 0);
    repeat (3) tick();
    check("stall_tready", s_axis_tready, 1'b0);
    check("stall_cnt", frame_cnt, 16'd2);
    release_bank();
    check("tready_after_release", s_axis_tready, 1'b1);
    check("fr_bank1", frame_ready, 1'b1);
    send_beat(beat(24'h200000, 0), 1'b0);
    for (int i = 1; i < 256; i++) send_beat(beat(24'h200000, i), (i == 255));
    check("cnt_frame3", frame_cnt, 16'd3);
    check("tready_full_again", s_axis_tready, 1'b0);
    rd(8'd3, beat(24'h100000, 3));
    release_bank();
    check("fr_bank0", frame_ready, 1'b1);
    rd(8'd200, beat(24'h200000, 200));

    // Same-cycle read and release reads the old bank
    rd_en = 1'b1;
    rd_addr = 8'd7;
    rd_release = 1'b1;
    exp_q.push_back(stored(beat(24'h200000, 7)));
    tick();
    rd_en = 1'b0;
    rd_release = 1'b0;
    check("rd_rel_valid", rd_valid, 1'b1);
    check("rd_rel_fr", frame_ready, 1'b0);

    // Frame close on one bank concurrent with release of the other
    send_frame(24'h300000, 256, 255);
    for (int i = 0; i < 255; i++) send_beat(beat(24'h400000, i), 1'b0);
    rd_release = 1'b1;
    send_beat(beat(24'h400000, 255), 1'b1);
    rd_release = 1'b0;
    check("simul_cnt", frame_cnt, 16'd5);
    check("simul_fr", frame_ready, 1'b1);
    check("simul_tready", s_axis_tready, 1'b1);
    rd(8'd255, beat(24'h400000, 255));
    rd(8'd9, beat(24'h400000, 9));
    tick();

    // Early tlast
    do_reset(2);
    check("rst2_cnt", frame_cnt, 16'd0);
    send_frame(24'h500000, 100, 99);
    check("early_err", err_tlast_early, 1'b1);
    check("early_missing", err_tlast_missing, 1'b0);
    check("early_cnt", frame_cnt, 16'd1);
    check("early_fr", frame_ready, 1'b1);
    send_frame(24'h600000, 256, 255);
    check("early_cnt2", frame_cnt, 16'd2);
    rd(8'd99, beat(24'h500000, 99));
    release_bank();
    rd(8'd0, beat(24'h600000, 0));
    rd(8'd255, beat(24'h600000, 255));
    tick();

    // Missing tlast
    do_reset(2);
    check("rst3_err_early", err_tlast_early, 1'b0);
    send_frame(24'h700000, 256, -1);
    check("miss_err", err_tlast_missing, 1'b1);
    check("miss_early", err_tlast_early, 1'b0);
    check("miss_cnt", frame_cnt, 16'd1);
    check("miss_fr", frame_ready, 1'b1);
    send_frame(24'h800000, 256, -1);
    check("miss_cnt2", frame_cnt, 16'd2);
    check("miss_tready", s_axis_tready, 1'b0);
    release_bank();
    rd(8'd0, beat(24'h800000, 0));
    tick();
    release_bank();
    check("empty_fr", frame_ready, 1'b0);

    // Reads and releases ignored with no frame ready
    rd_en = 1'b1;
    rd_addr = 8'd5;
    tick();
    rd_en = 1'b0;
    check("noready_valid", rd_valid, 1'b0);
    check("noready_hold", rd_data, stored(beat(24'h800000, 0)));
    release_bank();
    send_frame(24'h900000, 256, 255);
    check("norel_cnt", frame_cnt, 16'd3);
    check("norel_fr", frame_ready, 1'b1);
    rd(8'd128, beat(24'h900000, 128));
    tick();

    // Reset mid-frame, then a fresh frame carrying a phase marker at bin 5
    send_frame(24'hA00000, 120, -1);
    do_reset(2);
    check("midrst_fr", frame_ready, 1'b0);
    check("midrst_cnt", frame_cnt, 16'd0);
    check("midrst_err", err_tlast_missing, 1'b0);
    for (int i = 0; i < 256; i++)
      send_beat((i == 5) ? 48'hABCDEF_123456 : beat(24'hB00000, i), (i == 255));
    check("fresh_cnt", frame_cnt, 16'd1);
    check("fresh_fr", frame_ready, 1'b1);
    rd(8'd0, beat(24'hB00000, 0));
    rd(8'd119, beat(24'hB00000, 119));
    rd(8'd255, beat(24'hB00000, 255));
    rd(8'd5, 48'hABCDEF_123456);
    tick();
`ifdef PHASE_STORE_EN
    check("phase_bin5", rd_data, 48'hABCDEF_123456);
`else
    check("mag_bin5", rd_data, 24'h123456);
`endif

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_mag_frame_buffer.md
Name: fft_mag_frame_buffer

Overview:
Sits directly downstream of the CORDIC translate stage that is fed by the half-spectrum FFT filter. Captures each 256-bin magnitude frame into one bank of an internal ping-pong buffer. Exposes completed frames to the processor/BRAM controller through a simple synchronous read port. Backpressures the CORDIC (and, through the filter, the FFT) when both banks hold unread frames.

Parameters:
DATA_WIDTH, 48, width of the CORDIC output beat: magnitude in [MAG_WIDTH-1:0], phase in [DATA_WIDTH-1:MAG_WIDTH].
MAG_WIDTH, 24, stored magnitude width.
BINS, 256, bins per frame (half of the 512-point FFT).
ADDR_WIDTH, 8, log2(BINS).

Ports:
aclk  in  1  clock
aresetn  in  1  reset; synchronous, active-low
s_axis_tdata  in  DATA_WIDTH  CORDIC result {phase, magnitude}
s_axis_tvalid  in  1  input beat valid
s_axis_tlast  in  1  end of frame (expected on bin 255)
s_axis_tready  out  1  buffer can accept a beat
rd_en  in  1  read strobe
rd_addr  in  ADDR_WIDTH  bin index to read
rd_data  out  RD_WIDTH  read data; RD_WIDTH = MAG_WIDTH, or DATA_WIDTH with PHASE_STORE_EN
rd_valid  out  1  rd_data valid, one-cycle pulse
rd_release  in  1  pulse: consumer has finished the current read bank
frame_ready  out  1  read bank holds a complete frame
frame_cnt  out  16  completed frames written, wraps at 65535->0
err_tlast_early  out  1  sticky: tlast seen before bin BINS-1
err_tlast_missing  out  1  sticky: bin BINS-1 accepted without tlast

Behaviour:
- State: two banks of BINS entries; full[1:0]; wr_bank, rd_bank (1 bit each); wr_cnt (ADDR_WIDTH).
- Reset: full=0, wr_bank=rd_bank=0, wr_cnt=0, frame_cnt=0, both error flags 0, rd_valid=0, rd_data=0, frame_ready=0, s_axis_tready=0 during reset. Memory contents are not cleared.
- Reset mid-frame discards the partial frame; the next accepted beat is bin 0 of bank 0.
- s_axis_tready = aresetn_q && !full[wr_bank]. This is registered-free combinational from flags and does not depend on tvalid.
- Accept condition: tvalid && tready. On accept, write mem[wr_bank][wr_cnt] <= tdata[MAG_WIDTH-1:0], then increment wr_cnt.
- Frame close: on an accepted beat with tlast=1 or wr_cnt==BINS-1. Effects:
  - full[wr_bank] <= 1
  - wr_bank toggles
  - wr_cnt <= 0
  - frame_cnt increments
- Error flags:
  - tlast=1 with wr_cnt<BINS-1: set err_tlast_early. The frame still closes short; unwritten entries keep stale data.
  - wr_cnt==BINS-1 with tlast=0: set err_tlast_missing. The frame still closes.
  - Both flags clear only on reset.
- frame_ready = full[rd_bank]. It asserts the cycle after the closing beat is accepted, if that bank is the read bank.
- Read timing:
  - rd_en=1 with frame_ready=1 produces rd_data = mem[rd_bank][rd_addr] and rd_valid=1 on the next cycle.
  - rd_en with frame_ready=0 is ignored: rd_valid stays 0 and rd_data holds.
  - Back-to-back rd_en gives one result per cycle.
- rd_release with frame_ready=1: full[rd_bank] <= 0 and rd_bank toggles. rd_release with frame_ready=0 is ignored.
- Same-cycle rd_en and rd_release: the read uses the bank before the toggle.
- Simultaneous frame close on one bank and release of the other: both take effect in the same cycle.
- Both banks full: tready=0 until a release. With no release, the cycle after a release pulse sees tready=1.
- Single-frame latency: beat to readable is 1 cycle after the closing beat.

Optional Feature:
- Macro: PHASE_STORE_EN.
- Defined: memory width is DATA_WIDTH and stores the full {phase, magnitude} beat; rd_data is DATA_WIDTH wide.
- Undefined: only magnitude is stored; rd_data is MAG_WIDTH wide and phase bits are dropped.
- Control behaviour is identical in both builds.

Test Plan:
- Reset, then 256 beats with tdata[23:0]=bin index and tlast on beat 255 -> frame_ready=1 one cycle after the last beat; reading addr 0, 17, 255 returns 0, 17, 255 with rd_valid one cycle after each rd_en; frame_cnt=1.
- Three full frames sent with no rd_release -> tready drops to 0 after frame 2 closes; frame 3 beat 0 stalls; one rd_release re-raises tready the next cycle and frame 3 lands in bank 0; a subsequent read shows frame 2 data.
- tlast on beat 99 -> err_tlast_early=1, frame closes with frame_cnt=1; the next beat is written to bin 0 of bank 1.
- 256 beats with no tlast -> err_tlast_missing=1 and the frame closes at beat 255; beat 256 is bin 0 of the next frame.
- rd_en and rd_release with frame_ready=0 -> no rd_valid and no bank change. Reset asserted at beat 120 -> after reset, frame_ready=0, frame_cnt=0, and a fresh 256-beat frame is read back correctly.
- PHASE_STORE_EN build: tdata=48'hABCDEF_123456 at bin 5 -> reading addr 5 returns 48'hABCDEF_123456. Default build returns 24'h123456.
